// File: rtl/serial_adder8_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : serial_adder8_if
// Description : Handshake and data bundle between a serial_adder8 and its
//               requester/consumer. The requester side is the master; the
//               adder itself is the slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface serial_adder8_if;
   logic       i_w_start;
   logic [7:0] i_w_A;
   logic [7:0] i_w_B;
   logic       i_w_carry_in;
   logic       i_w_ack;
   logic [7:0] o_w_sum;
   logic       o_w_carry_out;
   logic       o_w_busy;
   logic       o_w_valid;

   modport slave (
      input  i_w_start,
      input  i_w_A,
      input  i_w_B,
      input  i_w_carry_in,
      input  i_w_ack,
      output o_w_sum,
      output o_w_carry_out,
      output o_w_busy,
      output o_w_valid
   );

   modport master (
      output i_w_start,
      output i_w_A,
      output i_w_B,
      output i_w_carry_in,
      output i_w_ack,
      input  o_w_sum,
      input  o_w_carry_out,
      input  o_w_busy,
      input  o_w_valid
   );
endinterface
`default_nettype wire

// File: rtl/serial_adder8.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : serial_adder8
// Description : 8-bit bit-serial adder. Operands are captured on an accepted
//               start, one bit is added per clock (LSB first), and the result
//               is presented with a valid/ack handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module serial_adder8 (
   input  wire              i_w_clk,
   input  wire              i_w_rst_n,
   serial_adder8_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] res_q, res_d;
   logic       c_q, c_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sum_q, sum_d;
   logic       cout_q, cout_d;

   // Full-adder slice working on the current LSBs of the operand shifters
   logic       w_bit_s;
   logic       w_bit_c;
   assign w_bit_s = a_q[0] ^ b_q[0] ^ c_q;
   assign w_bit_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

   // State and datapath registers; reset clears everything without a clock
   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         state_q <= S_IDLE;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         res_q   <= 8'h00;
         c_q     <= 1'b0;
         cnt_q   <= 3'd0;
         sum_q   <= 8'h00;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // Next-state and datapath update: capture, shift-add, publish, handshake
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         S_IDLE: begin
            if (bus.i_w_start) begin
               a_d     = bus.i_w_A;
               b_d     = bus.i_w_B;
               c_d     = bus.i_w_carry_in;
               cnt_d   = 3'd0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d = {w_bit_s, res_q[7:1]};
            a_d   = {1'b0, a_q[7:1]};
            b_d   = {1'b0, b_q[7:1]};
            c_d   = w_bit_c;
            cnt_d = cnt_q + 3'd1;
            // The published result only moves on the edge that finishes bit 7
            if (cnt_q == 3'd7) begin
               sum_d   = {w_bit_s, res_q[7:1]};
               cout_d  = w_bit_c;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Start is deliberately not looked at here, even alongside ack
            if (bus.i_w_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.o_w_sum       = sum_q;
   assign bus.o_w_carry_out = cout_q;
   assign bus.o_w_busy      = (state_q == S_RUN);
   assign bus.o_w_valid     = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder8.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_serial_adder8
// Description : Scoreboard bench for serial_adder8. The driver pushes the
//               arithmetic expectation on every accepted start; a monitor pops
//               and compares whenever valid rises.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_serial_adder8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   serial_adder8_if bus ();

   serial_adder8 dut (
      .i_w_clk   (clk),
      .i_w_rst_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Cycle stamp used to measure start-to-valid latency
   always @(posedge clk) cyc <= cyc + 1;

   int         checks   = 0;
   int         failures = 0;
   logic [8:0] exp_q[$];
   int         acc_q[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Reference: plain 9-bit arithmetic sum, carry out in bit 8
   function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
      int s;
      s = int'(a) + int'(b) + int'(cin);
      return s[8:0];
   endfunction

   // Drive a start while idle; the next edge must accept it
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input bit noise);
      bus.i_w_A        = a;
      bus.i_w_B        = b;
      bus.i_w_carry_in = cin;
      bus.i_w_start    = 1'b1;
      bus.i_w_ack      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(ref_add(a, b, cin));
      acc_q.push_back(cyc);
      chk("accept_busy", int'(bus.o_w_busy), 1);
      bus.i_w_start = 1'b0;
      if (noise) begin
         bus.i_w_A        = 8'($urandom);
         bus.i_w_B        = 8'($urandom);
         bus.i_w_carry_in = 1'($urandom);
      end
   endtask

   // Wait (bounded) for valid, optionally poking start/ack/operands meanwhile
   task automatic wait_valid(input bit noise, output bit got);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (bus.o_w_valid) begin
            got = 1'b1;
         end else begin
            chk("busy_run", int'(bus.o_w_busy), 1);
            if (noise) begin
               bus.i_w_start = ($urandom_range(0, 2) == 0);
               bus.i_w_ack   = ($urandom_range(0, 2) == 0);
               bus.i_w_A     = 8'($urandom);
               bus.i_w_B     = 8'($urandom);
            end
            @(negedge clk);
         end
      end
      bus.i_w_start = 1'b0;
      bus.i_w_ack   = 1'b0;
      if (!got) chk("valid_timeout", 0, 1);
   endtask

   // Hold DONE for dly cycles, then acknowledge; DUT must be idle afterwards
   task automatic ack_op(input int dly, input bit noise);
      for (int i = 0; i < dly; i++) begin
         if (noise) bus.i_w_start = 1'($urandom);
         @(negedge clk);
         chk("valid_hold", int'(bus.o_w_valid), 1);
      end
      bus.i_w_ack = 1'b1;
      if (noise) bus.i_w_start = 1'($urandom);
      @(negedge clk);
      bus.i_w_ack   = 1'b0;
      bus.i_w_start = 1'b0;
      chk("idle_after_ack", int'({bus.o_w_busy, bus.o_w_valid}), 0);
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input int dly, input bit noise);
      bit got;
      start_op(a, b, cin, noise);
      wait_valid(noise, got);
      if (got) ack_op(dly, noise);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit got;
      bus.i_w_start    = 1'b0;
      bus.i_w_ack      = 1'b0;
      bus.i_w_A        = 8'h00;
      bus.i_w_B        = 8'h00;
      bus.i_w_carry_in = 1'b0;

      // Monitor: compare on every rising valid, and check result stability
      fork
         begin : monitor
            logic       pv;
            logic [8:0] last;
            logic [8:0] cur;
            logic [8:0] e;
            int         a;
            pv   = 1'b0;
            last = 9'h000;
            forever begin
               @(negedge clk);
               cur = {bus.o_w_carry_out, bus.o_w_sum};
               if (!rst_n) begin
                  pv = 1'b0;
               end else if (bus.o_w_valid && !pv) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_result", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     a = acc_q.pop_front();
                     chk("result", int'(cur), int'(e));
                     chk("latency", cyc - a, 8);
                  end
                  pv = 1'b1;
               end else begin
                  chk("sum_hold", int'(cur), int'(last));
                  pv = bus.o_w_valid;
               end
               last = cur;
            end
         end
      join_none

      // Reset values before any clock edge
      #2;
      chk("rst_sum",   int'(bus.o_w_sum), 0);
      chk("rst_cout",  int'(bus.o_w_carry_out), 0);
      chk("rst_busy",  int'(bus.o_w_busy), 0);
      chk("rst_valid", int'(bus.o_w_valid), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed arithmetic cases
      run_op(8'h3C, 8'h42, 1'b0, 2, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1, 1, 1'b0);

      // Second start during RUN must be ignored
      start_op(8'h10, 8'h20, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.i_w_start = 1'b1;
      bus.i_w_A     = 8'hAA;
      bus.i_w_B     = 8'h55;
      @(negedge clk);
      bus.i_w_start = 1'b0;
      wait_valid(1'b0, got);
      if (got) ack_op(1, 1'b0);
      repeat (12) @(negedge clk);
      chk("no_queued_start", int'({bus.o_w_busy, bus.o_w_valid}), 0);

      // Long DONE hold, then ack and start together; start honoured next cycle
      start_op(8'h5A, 8'hA5, 1'b1, 1'b0);
      wait_valid(1'b0, got);
      ack_op(20, 1'b0);
      // ack_op above already released ack; redo the ack+start overlap explicitly
      start_op(8'h80, 8'h80, 1'b0, 1'b0);
      wait_valid(1'b0, got);
      bus.i_w_ack      = 1'b1;
      bus.i_w_start    = 1'b1;
      bus.i_w_A        = 8'h12;
      bus.i_w_B        = 8'h34;
      bus.i_w_carry_in = 1'b0;
      @(negedge clk);
      bus.i_w_ack = 1'b0;
      chk("ack_start_idle", int'({bus.o_w_busy, bus.o_w_valid}), 0);
      @(posedge clk);
      @(negedge clk);
      exp_q.push_back(ref_add(8'h12, 8'h34, 1'b0));
      acc_q.push_back(cyc);
      chk("start_after_ack", int'(bus.o_w_busy), 1);
      bus.i_w_start = 1'b0;
      wait_valid(1'b0, got);
      if (got) ack_op(0, 1'b0);

      // Asynchronous reset mid-RUN abandons the operation
      run_op(8'h3C, 8'h42, 1'b0, 0, 1'b0);
      start_op(8'h77, 8'h88, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_sum",   int'(bus.o_w_sum), 0);
      chk("arst_cout",  int'(bus.o_w_carry_out), 0);
      chk("arst_busy",  int'(bus.o_w_busy), 0);
      chk("arst_valid", int'(bus.o_w_valid), 0);
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      run_op(8'h01, 8'h01, 1'b0, 1, 1'b0);

      // Randomised operations with random handshake timing and noise
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 4), 1'b1);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_adder8.md
SERIAL_ADDER8 -- requirements
Module: serial_adder8

Interface
REQ-001 SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 i_w_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 i_w_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_w_start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 i_w_A  input  8  augend; captured on the accepted start edge.
REQ-006 i_w_B  input  8  addend; captured on the accepted start edge.
REQ-007 i_w_carry_in  input  1  carry into bit 0; captured on the accepted start edge.
REQ-008 i_w_ack  input  1  consumer acknowledge of the result; sampled only in DONE.
REQ-009 o_w_sum  output  8  registered result A+B+carry_in, modulo 256.
REQ-010 o_w_carry_out  output  1  registered carry out of bit 7.
REQ-011 o_w_busy  output  1  high in RUN.
REQ-012 o_w_valid  output  1  high in DONE; o_w_sum and o_w_carry_out are valid while high.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on a rising edge with i_w_start=1; A, B and carry_in latched into internal shift registers and carry flop; bit counter cleared to 0.
REQ-015 In RUN, one bit per cycle, LSB first: s = a[k]^b[k]^c, c' = a[k]&b[k] | c&(a[k]^b[k]); s shifted into the result shift register from the MSB end; operand registers shifted right by one.
REQ-016 Bit counter is 3 bits; RUN -> DONE on the edge that processes bit 7 (counter=7); counter wraps to 0.
REQ-017 On the RUN -> DONE edge, o_w_sum is loaded with the complete 8-bit result and o_w_carry_out with c'.
REQ-018 Latency: o_w_valid rises exactly 8 clock edges after the accepted start edge.
REQ-019 o_w_sum and o_w_carry_out SHALL change only on the RUN -> DONE edge; otherwise they hold the last result, including through IDLE and RUN.
REQ-020 DONE -> IDLE on the edge where i_w_ack=1; DONE persists indefinitely while i_w_ack=0.
REQ-021 i_w_start in RUN or DONE SHALL be ignored and not queued; operands changing after capture SHALL not affect the result.
REQ-022 i_w_start and i_w_ack both high in DONE: ack is honoured, start ignored; the next start is accepted no earlier than the following cycle in IDLE.
REQ-023 i_w_ack in IDLE or RUN SHALL be ignored.
REQ-024 Back-to-back throughput: one result per 10 cycles (start edge, 8 RUN edges, 1 ack edge) when start and ack are held high.

Reset
REQ-025 i_w_rst_n=0 SHALL immediately, without a clock, force state IDLE, o_w_sum=8'h00, o_w_carry_out=0, o_w_busy=0, o_w_valid=0, and clear operand, result, carry and counter registers.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no partial result appears on o_w_sum.
REQ-027 After deassertion, the first rising edge with i_w_start=1 SHALL be accepted.

Verification
REQ-028 A=8'h3C, B=8'h42, cin=0, start pulse -> busy 8 cycles, then valid=1, sum=8'h7E, cout=0.
REQ-029 A=8'hFF, B=8'h01, cin=0 -> sum=8'h00, cout=1; A=8'hFF, B=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-030 Start with A=8'h10, B=8'h20; 3 cycles later pulse start with A=8'hAA, B=8'h55 -> second start ignored, result sum=8'h30, cout=0.
REQ-031 Hold ack=0 for 20 cycles in DONE -> valid and sum stable; then ack=1 and start=1 together -> IDLE next, no new op; start next cycle accepted.
REQ-032 Reset pulse 4 cycles into RUN with previous sum=8'h7E -> all outputs 0 asynchronously; fresh op A=8'h01, B=8'h01 -> sum=8'h02.
REQ-033 Randomised: 1000 ops, random A, B, cin, start and ack timing -> every {cout,sum} equals A+B+cin, valid latency always 8.
